// File: rtl/pipeline_hazard_ctrl.sv
// ID/EX hazard controller: load-use stalls, taken-jump flush FSM, operand
// forwarding from shadowed EX/MEM and MEM/WB destinations, saturating counters.
//
// state   | meaning
// S_RUN   | normal issue; load-use stalls and jump detection active
// S_FLUSH | squashing wrong-path fetches after a taken jump
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rs1,
    input  logic [4:0]       i_ex_rs2,
    input  logic [4:0]       i_ex_write_reg,
    input  logic             i_ex_reg_wrenable,
    input  logic             i_ex_mem_to_reg,
    input  logic             i_ex_branch_taken,
    input  logic             i_cnt_clear,
    output logic             o_stall_pc,
    output logic             o_bubble_ex,
    output logic             o_flush_if_id,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_flushing,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       r_state;
    logic [2:0]       r_fc;
    logic [4:0]       r_mem_wr_reg;
    logic             r_mem_wren;
    logic [4:0]       r_wb_wr_reg;
    logic             r_wb_wren;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic             w_hz;
    logic             w_in_flush;
    logic             w_jump;
    logic             w_flush;
    logic             w_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    always_comb begin
        w_hz = i_ex_reg_wrenable && i_ex_mem_to_reg && (i_ex_write_reg != 5'd0) &&
               ((i_id_use_rs1 && (i_id_rs1 == i_ex_write_reg)) ||
                (i_id_use_rs2 && (i_id_rs2 == i_ex_write_reg)));
        w_in_flush = (r_state == S_FLUSH);
        // a taken jump is only honoured in RUN; in FLUSH the EX slot is a bubble
        w_jump  = !w_in_flush && i_ex_branch_taken;
        w_flush = w_in_flush || w_jump;
        w_stall = w_hz && !w_flush;
    end

    always_comb begin
        w_fwd_a = 2'b00;
        if (r_mem_wren && (r_mem_wr_reg != 5'd0) && (r_mem_wr_reg == i_ex_rs1))
            w_fwd_a = 2'b01;
        else if (r_wb_wren && (r_wb_wr_reg != 5'd0) && (r_wb_wr_reg == i_ex_rs1))
            w_fwd_a = 2'b10;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (r_mem_wren && (r_mem_wr_reg != 5'd0) && (r_mem_wr_reg == i_ex_rs2))
            w_fwd_b = 2'b01;
        else if (r_wb_wren && (r_wb_wr_reg != 5'd0) && (r_wb_wr_reg == i_ex_rs2))
            w_fwd_b = 2'b10;
    end

    // outputs are forced low for the whole time reset is held
    assign o_stall_pc    = rst_n && w_stall;
    assign o_bubble_ex   = rst_n && (w_flush || w_hz);
    assign o_flush_if_id = rst_n && w_flush;
    assign o_flushing    = rst_n && w_in_flush;
    assign o_fwd_a       = rst_n ? w_fwd_a : 2'b00;
    assign o_fwd_b       = rst_n ? w_fwd_b : 2'b00;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_fc    <= 3'd0;
        end else if (w_in_flush) begin
            if (r_fc == 3'd1) begin
                r_state <= S_RUN;
                r_fc    <= 3'd0;
            end else begin
                r_fc <= r_fc - 3'd1;
            end
        end else if (w_jump && (FLUSH_CYCLES > 1)) begin
            r_state <= S_FLUSH;
            r_fc    <= 3'(FLUSH_CYCLES - 1);
        end
    end

    // the jump's own EX instruction retires; later flush cycles do not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_wr_reg <= 5'd0;
            r_mem_wren   <= 1'b0;
            r_wb_wr_reg  <= 5'd0;
            r_wb_wren    <= 1'b0;
        end else begin
            r_mem_wr_reg <= i_ex_write_reg;
            r_mem_wren   <= i_ex_reg_wrenable && !w_in_flush;
            r_wb_wr_reg  <= r_mem_wr_reg;
            r_wb_wren    <= r_mem_wren;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (i_cnt_clear) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_jump && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// every output checked each cycle against a write-history reference model.
module tb_pipeline_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int SAT          = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_write_reg;
    logic             id_use_rs1, id_use_rs2, ex_reg_wrenable, ex_mem_to_reg;
    logic             ex_branch_taken, cnt_clear;
    logic             o_stall_pc, o_bubble_ex, o_flush_if_id, o_flushing;
    logic [1:0]       o_fwd_a, o_fwd_b;
    logic [CNT_W-1:0] o_stall_count, o_flush_count;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
        .i_ex_write_reg(ex_write_reg), .i_ex_reg_wrenable(ex_reg_wrenable),
        .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_branch_taken(ex_branch_taken),
        .i_cnt_clear(cnt_clear),
        .o_stall_pc(o_stall_pc), .o_bubble_ex(o_bubble_ex),
        .o_flush_if_id(o_flush_if_id), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_flushing(o_flushing), .o_stall_count(o_stall_count),
        .o_flush_count(o_flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {int rd; bit wr;} wr_t;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t wq[$];          // retired writes, youngest first
    int  flush_rem;      // cycles still left in the post-jump window
    int  m_stall, m_flush;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        wr_t z;
        z.rd = 0; z.wr = 1'b0;
        wq.delete();
        repeat (2) wq.push_back(z);
        flush_rem = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    function automatic int fwd_exp(input int src);
        for (int i = 0; i < 2; i++)
            if (wq[i].wr && wq[i].rd != 0 && wq[i].rd == src) return (i == 0) ? 1 : 2;
        return 0;
    endfunction

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_write_reg = 0;
        ex_reg_wrenable = 0; ex_mem_to_reg = 0; ex_branch_taken = 0; cnt_clear = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_write_reg = rd; ex_mem_to_reg = 1; ex_reg_wrenable = 1;
        id_rs1 = rd; id_use_rs1 = 1;
    endtask

    // one pipeline cycle: check at negedge, advance the model at posedge
    task automatic cycle();
        bit  in_fl, fl, hz, st;
        wr_t e;
        @(negedge clk);
        in_fl = flush_rem > 0;
        fl    = in_fl || ex_branch_taken;
        hz    = ex_reg_wrenable && ex_mem_to_reg && ex_write_reg != 0 &&
                ((id_use_rs1 && id_rs1 == ex_write_reg) || (id_use_rs2 && id_rs2 == ex_write_reg));
        st    = hz && !fl;
        chk("stall_pc",    int'(o_stall_pc),    int'(st));
        chk("bubble_ex",   int'(o_bubble_ex),   int'(fl || hz));
        chk("flush_if_id", int'(o_flush_if_id), int'(fl));
        chk("flushing",    int'(o_flushing),    int'(in_fl));
        chk("fwd_a",       int'(o_fwd_a),       fwd_exp(int'(ex_rs1)));
        chk("fwd_b",       int'(o_fwd_b),       fwd_exp(int'(ex_rs2)));
        chk("stall_count", int'(o_stall_count), m_stall);
        chk("flush_count", int'(o_flush_count), m_flush);
        @(posedge clk);
        if (cnt_clear) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (st && m_stall < SAT) m_stall++;
            if (!in_fl && ex_branch_taken && m_flush < SAT) m_flush++;
        end
        e.rd = int'(ex_write_reg);
        e.wr = ex_reg_wrenable && !in_fl;
        wq.push_front(e);
        void'(wq.pop_back());
        if (in_fl) flush_rem--;
        else if (ex_branch_taken) flush_rem = FLUSH_CYCLES - 1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall_pc"},    int'(o_stall_pc),    0);
        chk({tag, "_bubble_ex"},   int'(o_bubble_ex),   0);
        chk({tag, "_flush_if_id"}, int'(o_flush_if_id), 0);
        chk({tag, "_flushing"},    int'(o_flushing),    0);
        chk({tag, "_fwd_a"},       int'(o_fwd_a),       0);
        chk({tag, "_fwd_b"},       int'(o_fwd_b),       0);
        chk({tag, "_stall_count"}, int'(o_stall_count), 0);
        chk({tag, "_flush_count"}, int'(o_flush_count), 0);
    endtask

    initial begin
        set_idle();
        m_reset();
        rst_n = 1'b0;
        set_load_use(5'd5);
        ex_branch_taken = 1;
        #12;
        chk_all_zero("in_reset");
        set_idle();
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        // load-use on r5, then the consumer reaches EX after the bubble
        set_load_use(5'd5); ex_rs1 = 5'd3;
        cycle();
        set_idle(); ex_rs1 = 5'd5;
        cycle();
        cycle();
        chk("lu_stall_count", int'(o_stall_count), 1);

        // r0 never stalls nor forwards
        set_idle(); set_load_use(5'd0);
        cycle();
        set_idle(); ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        cycle();

        // two back-to-back writers of r7, consumer on operand B
        set_idle(); ex_write_reg = 5'd7; ex_reg_wrenable = 1;
        cycle();
        cycle();
        set_idle(); ex_rs2 = 5'd7;
        cycle();
        cycle();

        // taken jump, second pulse inside the window is ignored
        set_idle(); ex_branch_taken = 1;
        cycle();
        cycle();
        set_idle();
        cycle();
        chk("jump_flush_count", int'(o_flush_count), 1);

        // hazard and jump together: flush wins
        set_load_use(5'd9); ex_branch_taken = 1;
        cycle();
        set_idle();
        cycle();
        cycle();
        chk("simul_stall_count", int'(o_stall_count), 1);

        // saturation then clear
        set_load_use(5'd4);
        repeat (SAT + 4) cycle();
        chk("sat_stall_count", int'(o_stall_count), SAT);
        set_idle(); cnt_clear = 1;
        cycle();
        cnt_clear = 0;
        chk("clr_stall_count", int'(o_stall_count), 0);
        chk("clr_flush_count", int'(o_flush_count), 0);

        // reset asserted mid-flush
        set_idle(); ex_branch_taken = 1;
        cycle();
        set_load_use(5'd6); ex_rs1 = 5'd6;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_flush_rst");
        m_reset();
        set_idle();
        #2 rst_n = 1'b1;
        cycle();

        // random traffic on a small register set to provoke hits
        repeat (1500) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_rs1          = 5'($urandom_range(0, 3));
            ex_rs2          = 5'($urandom_range(0, 3));
            ex_write_reg    = 5'($urandom_range(0, 3));
            ex_reg_wrenable = 1'($urandom_range(0, 1));
            ex_mem_to_reg   = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            cnt_clear       = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
